divider_48by24: RTL

Sequential radix-2 restoring divider that computes quotient and remainder of a 48-bit unsigned dividend by a 24-bit unsigned divisor. It is the inverse datapath to the 24×24 multiplier: it accepts that block's 48-bit product widths and recovers one operand, for example for normalisation, scaling and self-check paths. It produces one quotient bit per cycle under a start/done handshake, so a single small subtractor replaces a large combinational array.

---
 rtl/divider_48by24.sv | 108 ++++++++++
 1 files changed

// File: rtl/divider_48by24.sv
// divider_48by24: sequential radix-2 restoring divider, 48-bit dividend by
// 24-bit divisor. One quotient bit per CALC cycle under a start/done
// handshake. A zero divisor short-circuits straight to DONE with a saturated
// quotient and the low dividend bits as remainder.
module divider_48by24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dividend,
  input  logic [23:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [47:0] quotient,
  output logic [23:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_n;
  logic [47:0] dq;      // dividend shifting out the top, quotient shifting in
  logic [23:0] pr;      // partial remainder; always < divisor between steps
  logic [23:0] dvs;     // latched divisor
  logic [5:0]  cnt;     // remaining CALC steps minus one

  // One restoring step. The shifted remainder needs a 25th bit only for the
  // compare; after a conditional subtract the result always fits 24 bits, so
  // the low 24 bits of a modular subtract are exact.
  logic [24:0] pr_sh;
  logic        ge;
  logic [23:0] pr_nxt;
  logic [47:0] dq_nxt;

  assign pr_sh  = {pr, dq[47]};
  assign ge     = (pr_sh >= {1'b0, dvs});
  assign pr_nxt = pr_sh[23:0] - (ge ? dvs : 24'd0);
  assign dq_nxt = {dq[46:0], ge};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (divisor == 24'd0) ? DONE : CALC;
      CALC: if (cnt == 6'd0) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered status flags, derived from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n == CALC);
      done <= (state_n == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result registers that only
  // change at acceptance (divide-by-zero) or at the final CALC step
  always_ff @(posedge clk) begin
    if (rst) begin
      dq          <= '0;
      pr          <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (divisor == 24'd0) begin
            quotient    <= '1;
            remainder   <= dividend[23:0];
            div_by_zero <= 1'b1;
          end else begin
            dq          <= dividend;
            dvs         <= divisor;
            pr          <= '0;
            cnt         <= 6'd47;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          dq <= dq_nxt;
          pr <= pr_nxt;
          if (cnt == 6'd0) begin
            quotient  <= dq_nxt;
            remainder <= pr_nxt;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
